// File: rtl/shift_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | shift_pkg: shared types and constants for the shift arbiter      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ROR2 = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | shifter: combinational barrel shifter, mode 0 = SLL, 1 = SRA     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in << amt;
    if (mode) begin
      data_out = $signed(data_in) >>> amt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | shift_arbiter: round-robin share of one shifter, adds ROR        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_id_q, resp_id_d;

  logic             grant_id;
  logic             sh_mode;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] sh_out;

  // Shifter is fed only from latched operands, never from request ports.
  shifter #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_shifter (
    .data_in (data_q),
    .amt     (sh_amt),
    .mode    (sh_mode),
    .data_out(sh_out)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    data_d      = data_q;
    amt_d       = amt_q;
    id_d        = id_q;
    tmp_d       = tmp_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    grant_id    = 1'b0;
    sh_mode     = 1'b0;
    sh_amt      = amt_q;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_id   = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op_d       = grant_id ? op_e'(req1_op) : op_e'(req0_op);
          data_d     = grant_id ? req1_data : req0_data;
          amt_d      = grant_id ? req1_amt : req0_amt;
          id_d       = grant_id;
          rr_ptr_d   = ~grant_id;
          state_d    = EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_SLL:  sh_mode = 1'b0;
          OP_SRA:  sh_mode = 1'b1;
          OP_PASS: sh_amt  = '0;
          // First ROR pass: left shift by (WIDTH - amt) mod WIDTH via 4-bit wrap.
          OP_ROR:  sh_amt  = -amt_q;
          default: sh_mode = 1'b0;
        endcase
        if (op_q == OP_ROR) begin
          tmp_d   = sh_out;
          state_d = ROR2;
        end else begin
          resp_data_d = sh_out;
          resp_id_d   = id_q;
          state_d     = DONE;
        end
      end

      ROR2: begin
        // Mask off the sign fill so only the logically shifted bits remain.
        sh_mode     = 1'b1;
        resp_data_d = (sh_out & ({WIDTH{1'b1}} >> amt_q)) | tmp_q;
        resp_id_d   = id_q;
        state_d     = DONE;
      end

      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_q        <= OP_SLL;
      data_q      <= '0;
      amt_q       <= '0;
      id_q        <= 1'b0;
      tmp_q       <= '0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      id_q        <= id_d;
      tmp_q       <= tmp_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == DONE);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_shift_arbiter: randomized and directed checks vs a model      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, rdy0, rdy1;
  logic [1:0]  op0, op1;
  logic [15:0] d0, d1;
  logic [3:0]  a0, a1;
  logic        rvalid, rready, rid;
  logic [15:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: one outstanding op at most
  bit          pend;
  logic [15:0] m_data;
  bit          m_id;
  int          resp_at;
  bit          last_id;
  int          cyc;
  int          mode;      // 0 directed, 1 both-valid SLL stream, 2 random
  int          bp_left;

  shift_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(v0),
    .req0_ready(rdy0),
    .req0_op   (op0),
    .req0_data (d0),
    .req0_amt  (a0),
    .req1_valid(v1),
    .req1_ready(rdy1),
    .req1_op   (op1),
    .req1_data (d1),
    .req1_amt  (a1),
    .resp_valid(rvalid),
    .resp_ready(rready),
    .resp_id   (rid),
    .resp_data (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] d,
                                         input logic [3:0] a);
    int unsigned x;
    int          s;
    x = d;
    case (op)
      2'd0: return 16'((x << a) & 32'hFFFF);
      2'd1: begin
        s = d[15] ? int'(x) - 65536 : int'(x);
        return 16'((s >>> a) & 32'hFFFF);
      end
      2'd2: return 16'(((x >> a) | (x << (16 - a))) & 32'hFFFF);
      default: return d;
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op);
    return (op == 2'd2) ? 3 : 2;
  endfunction

  task automatic new_req(input int port);
    if (port == 0) begin
      op0 = 2'($urandom); d0 = 16'($urandom); a0 = 4'($urandom);
    end else begin
      op1 = 2'($urandom); d1 = 16'($urandom); a1 = 4'($urandom);
    end
  endtask

  // One clock cycle: check outputs against the model, advance the model, update stimulus.
  task automatic run_cycle();
    bit exp_valid, g0, g1, hs;
    int c;
    #1;
    exp_valid = pend && (cyc >= resp_at);
    g0 = 0;
    g1 = 0;
    if (!pend) begin
      if (v0 && v1) begin
        if (last_id) g0 = 1; else g1 = 1;
      end else if (v0) g0 = 1;
      else if (v1) g1 = 1;
    end
    check("ready0", 16'(rdy0), 16'(g0));
    check("ready1", 16'(rdy1), 16'(g1));
    check("rvalid", 16'(rvalid), 16'(exp_valid));
    if (exp_valid) begin
      check("rdata", rdata, m_data);
      check("rid", 16'(rid), 16'(m_id));
    end
    hs = exp_valid && rready;
    if (exp_valid && bp_left > 0) bp_left--;
    c = cyc;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      pend = 0;
      last_id = 1;
    end else begin
      if (hs) pend = 0;
      if (g0) begin
        pend = 1; m_data = ref_op(op0, d0, a0); m_id = 0; last_id = 0; resp_at = c + lat(op0);
      end
      if (g1) begin
        pend = 1; m_data = ref_op(op1, d1, a1); m_id = 1; last_id = 1; resp_at = c + lat(op1);
      end
    end
    #1;
    rready = (bp_left == 0);
    case (mode)
      0: begin
        if (g0 && rst_n) v0 = 0;
        if (g1 && rst_n) v1 = 0;
      end
      1: begin
        if (g0) d0 = 16'($urandom);
        if (g1) d1 = 16'($urandom);
      end
      default: begin
        rready = bp_left == 0 && ($urandom_range(3) != 0);
        if (!v0 || g0) begin v0 = 1'($urandom); new_req(0); end
        else if ($urandom_range(7) == 0) v0 = 0;
        if (!v1 || g1) begin v1 = 1'($urandom); new_req(1); end
        else if ($urandom_range(7) == 0) v1 = 0;
      end
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while ((v0 || v1 || pend) && n < 40) begin
      run_cycle();
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: got busy expected idle (cycle %0d)", cyc);
    end
  endtask

  task automatic issue(input int port, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] a);
    if (port == 0) begin v0 = 1; op0 = op; d0 = d; a0 = a; end
    else begin v1 = 1; op1 = op; d1 = d; a1 = a; end
    drain();
  endtask

  initial begin
    rst_n = 0; v0 = 0; v1 = 0; rready = 1;
    op0 = 0; op1 = 0; d0 = 0; d1 = 0; a0 = 0; a1 = 0;
    pend = 0; last_id = 1; cyc = 0; mode = 0; bp_left = 0;
    m_data = 0; m_id = 0; resp_at = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check("reset_rvalid", 16'(rvalid), 16'd0);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_rid", 16'(rid), 16'd0);

    issue(0, 2'd0, 16'h0001, 4'd4);
    issue(1, 2'd1, 16'h8000, 4'd3);
    issue(0, 2'd2, 16'h1234, 4'd4);
    issue(1, 2'd2, 16'h8001, 4'd1);
    issue(0, 2'd2, 16'h8001, 4'd0);
    issue(1, 2'd3, 16'hBEEF, 4'd9);

    // both ports streaming SLL by 1
    mode = 1;
    v0 = 1; v1 = 1; op0 = 2'd0; op1 = 2'd0; a0 = 4'd1; a1 = 4'd1;
    d0 = 16'h0101; d1 = 16'h0202;
    repeat (14) run_cycle();

    // backpressure with both requesters still waiting
    bp_left = 5;
    rready = 0;
    repeat (12) run_cycle();
    mode = 0; v0 = 0; v1 = 0;
    drain();

    // reset while the second ROR pass is in flight
    v0 = 1; op0 = 2'd2; d0 = 16'hA5C3; a0 = 4'd5;
    while (!pend && cyc < 1000) run_cycle();
    run_cycle();
    rst_n = 0;
    run_cycle();
    rst_n = 1;
    v0 = 1; v1 = 1; op0 = 2'd0; op1 = 2'd0; d0 = 16'h0003; d1 = 16'h0005; a0 = 4'd2; a1 = 4'd2;
    drain();

    mode = 2;
    repeat (600) run_cycle();
    mode = 0; v0 = 0; v1 = 0; rready = 1; bp_left = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
